fetch_sequencer: RTL and testbench

//  Upstream stage of the control unit: owns the program counter, fetches each

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/step sequencer: owns the PC, fetches into the instruction register and emits T-states.
// Optional SINGLE_STEP_EN adds step_req, gating each fetch on a step request.
module fetch_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int NUM_STEPS = 5
) (
    input  logic              clk,
    input  logic              bReset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              step_done,
    input  logic              hlt,
`ifdef SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] instruction,
    output logic [2:0]        opcode,
    output logic [2:0]        sc,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_SC = 3'(NUM_STEPS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [DATA_W-1:0]   instruction_q, instruction_d;
    logic [2:0]          sc_q, sc_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                halted_q, halted_d;
    logic                go_s;

`ifdef SINGLE_STEP_EN
    assign go_s = step_req;
`else
    assign go_s = 1'b1;
`endif

    // Next-state and next-output logic for the fetch/wait/exec/halt sequence
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = mem_rd_q;
        instruction_d = instruction_q;
        sc_d          = sc_q;
        fetch_valid_d = 1'b0;
        halted_d      = halted_q;
        case (state_q)
            S_FETCH: begin
                if (go_s) begin
                    mem_addr_d = pc_q;
                    mem_rd_d   = 1'b1;
                    sc_d       = 3'd1;
                    state_d    = S_WAIT;
                end else begin
                    mem_rd_d   = 1'b0;
                    sc_d       = 3'd0;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    instruction_d = mem_rdata;
                    pc_d          = pc_q + ADDR_W'(1);
                    mem_rd_d      = 1'b0;
                    fetch_valid_d = 1'b1;
                    sc_d          = 3'd2;
                    state_d       = S_EXEC;
                end else begin
                    mem_rd_d      = 1'b1;
                end
            end
            S_EXEC: begin
                // Jump target is mirrored onto mem_addr so the next fetch address is visible early
                if (jump_en) begin
                    pc_d       = jump_addr;
                    mem_addr_d = jump_addr;
                end else begin
                    pc_d       = pc_q;
                end
                if (hlt) begin
                    state_d  = S_HALT;
                    sc_d     = 3'd0;
                    halted_d = 1'b1;
                    mem_rd_d = 1'b0;
                end else if ((sc_q == LAST_SC) || step_done) begin
                    state_d  = S_FETCH;
                    sc_d     = 3'd0;
                end else begin
                    sc_d     = sc_q + 3'd1;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d  = S_FETCH;
                sc_d     = 3'd0;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by bReset
    always_ff @(posedge clk or posedge bReset) begin
        if (bReset) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            instruction_q <= '0;
            sc_q          <= 3'd0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            instruction_q <= instruction_d;
            sc_q          <= sc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign instruction = instruction_q;
    assign opcode      = instruction_q[DATA_W-1:DATA_W-3];
    assign sc          = sc_q;
    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer using immediate assertions.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       bReset;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       step_done;
    logic       hlt;
`ifdef SINGLE_STEP_EN
    logic       step_req = 1'b1;
`endif
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] instruction;
    logic [2:0] opcode;
    logic [2:0] sc;
    logic [3:0] pc;
    logic       fetch_valid;
    logic       halted;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.ADDR_W(4), .DATA_W(8), .NUM_STEPS(5)) dut (
        .clk(clk), .bReset(bReset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .jump_en(jump_en), .jump_addr(jump_addr), .step_done(step_done), .hlt(hlt),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .instruction(instruction), .opcode(opcode),
        .sc(sc), .pc(pc), .fetch_valid(fetch_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bReset = 1'b1; mem_rdata = 8'h00; mem_ready = 1'b0;
        jump_en = 1'b0; jump_addr = 4'h0; step_done = 1'b0; hlt = 1'b0;
        tick(); tick();
        check("rst_pc", pc, 4'h0);
        check("rst_sc", sc, 3'd0);
        check("rst_instr", instruction, 8'h00);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_fv", fetch_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_mem_addr", mem_addr, 4'h0);
        bReset = 1'b0;

        // Reset in the middle of a pending read
        tick();
        check("wait_sc", sc, 3'd1);
        check("wait_mem_rd", mem_rd, 1'b1);
        tick();
        bReset = 1'b1;
        #1;
        check("midwait_rst_mem_rd", mem_rd, 1'b0);
        check("midwait_rst_pc", pc, 4'h0);
        check("midwait_rst_sc", sc, 3'd0);
        bReset = 1'b0;

        // Zero-wait fetch of A5
        mem_ready = 1'b1; mem_rdata = 8'hA5;
        tick();
        check("zw_sc1", sc, 3'd1);
        check("zw_mem_rd", mem_rd, 1'b1);
        check("zw_fv_sc1", fetch_valid, 1'b0);
        tick();
        check("zw_sc2", sc, 3'd2);
        check("zw_instr", instruction, 8'hA5);
        check("zw_opcode", opcode, 3'b101);
        check("zw_pc", pc, 4'h1);
        check("zw_fv_sc2", fetch_valid, 1'b1);
        check("zw_mem_rd_off", mem_rd, 1'b0);
        tick();
        check("zw_sc3", sc, 3'd3);
        check("zw_fv_sc3", fetch_valid, 1'b0);
        tick();
        check("zw_sc4", sc, 3'd4);
        tick();
        check("zw_sc0", sc, 3'd0);
        check("zw_pc_hold", pc, 4'h1);

        // Three wait cycles before ready
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ws_sc", sc, 3'd1);
            check("ws_mem_rd", mem_rd, 1'b1);
            check("ws_pc", pc, 4'h1);
        end
        check("ws_mem_addr", mem_addr, 4'h1);
        mem_ready = 1'b1; mem_rdata = 8'h3C;
        tick();
        check("ws_sc2", sc, 3'd2);
        check("ws_pc_inc", pc, 4'h2);
        check("ws_instr", instruction, 8'h3C);
        check("ws_opcode", opcode, 3'b001);
        check("ws_fv", fetch_valid, 1'b1);

        // Jump with early end at sc=2
        jump_en = 1'b1; jump_addr = 4'hC; step_done = 1'b1;
        tick();
        check("jmp_sc0", sc, 3'd0);
        check("jmp_mem_addr", mem_addr, 4'hC);
        check("jmp_pc", pc, 4'hC);
        jump_en = 1'b0; step_done = 1'b0;
        tick();
        check("jmp_fetch_sc", sc, 3'd1);
        check("jmp_fetch_addr", mem_addr, 4'hC);
        // Control inputs during WAIT must be ignored
        hlt = 1'b1; jump_en = 1'b1; jump_addr = 4'h3; step_done = 1'b1; mem_rdata = 8'h5A;
        tick();
        hlt = 1'b0; jump_en = 1'b0; step_done = 1'b0;
        check("ign_sc", sc, 3'd2);
        check("ign_pc", pc, 4'hD);
        check("ign_halted", halted, 1'b0);
        check("ign_opcode", opcode, 3'b010);

        // Move to pc=F, fetch to wrap, then halt at sc=3
        jump_en = 1'b1; jump_addr = 4'hF; step_done = 1'b1;
        tick();
        jump_en = 1'b0; step_done = 1'b0;
        check("j2_pc", pc, 4'hF);
        tick();
        check("j2_addr", mem_addr, 4'hF);
        mem_rdata = 8'hE1;
        tick();
        check("wrap_pc", pc, 4'h0);
        check("wrap_opcode", opcode, 3'b111);
        tick();
        check("h_sc3", sc, 3'd3);
        hlt = 1'b1; step_done = 1'b1;
        tick();
        check("h_halted", halted, 1'b1);
        check("h_sc", sc, 3'd0);
        check("h_mem_rd", mem_rd, 1'b0);
        check("h_pc", pc, 4'h0);
        hlt = 1'b0; jump_en = 1'b1; jump_addr = 4'h7; step_done = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hf_sc", sc, 3'd0);
            check("hf_halted", halted, 1'b1);
            check("hf_pc", pc, 4'h0);
            check("hf_mem_rd", mem_rd, 1'b0);
        end

        // Only reset leaves HALTED
        jump_en = 1'b0; step_done = 1'b0;
        bReset = 1'b1;
        #1;
        check("hr_halted", halted, 1'b0);
        check("hr_instr", instruction, 8'h00);
        bReset = 1'b0;
        tick();
        check("hr_sc1", sc, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
